// File: rtl/branch_resolve_arb_if.sv
// Request/comparator/result bundle for branch_resolve_arb.
//   slave  : the arbiter (takes requests and cmp_taken, drives grants, cmp operands, result)
//   master : the surrounding EX/redirect logic (or a testbench)
// Lane fields use the 0/1 suffix for the lane index.
interface branch_resolve_arb_if #(parameter int TAG_W = 4);
  logic             flush;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2:0]       req_op0, req_op1;
  logic [63:0]      req_r1_0, req_r2_0, req_r1_1, req_r2_1;
  logic [63:0]      req_pc0, req_pc1;
  logic [63:0]      req_tgt0, req_tgt1;
  logic             req_pred0, req_pred1;
  logic [TAG_W-1:0] req_tag0, req_tag1;
  logic [2:0]       cmp_op;
  logic [63:0]      cmp_r1, cmp_r2;
  logic             cmp_taken;
  logic             res_valid;
  logic             res_ready;
  logic             res_lane;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic             res_mispredict;
  logic [63:0]      res_redirect_pc;

  modport slave (
    input  flush, req_valid, req_op0, req_op1, req_r1_0, req_r2_0, req_r1_1, req_r2_1,
           req_pc0, req_pc1, req_tgt0, req_tgt1, req_pred0, req_pred1, req_tag0, req_tag1,
           cmp_taken, res_ready,
    output req_ready, cmp_op, cmp_r1, cmp_r2,
           res_valid, res_lane, res_tag, res_taken, res_mispredict, res_redirect_pc
  );

  modport master (
    output flush, req_valid, req_op0, req_op1, req_r1_0, req_r2_0, req_r1_1, req_r2_1,
           req_pc0, req_pc1, req_tgt0, req_tgt1, req_pred0, req_pred1, req_tag0, req_tag1,
           cmp_taken, res_ready,
    input  req_ready, cmp_op, cmp_r1, cmp_r2,
           res_valid, res_lane, res_tag, res_taken, res_mispredict, res_redirect_pc
  );
endinterface

// File: rtl/branch_resolve_arb.sv
// branch_resolve_arb: round-robin share of one branch comparator between lane 0
// (main EX) and lane 1 (replay), with a one-entry registered result stage that
// produces taken / mispredict / redirect PC for the fetch/flush logic.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : requests, comparator mux + cmp_taken, result stage
//   stat_resolved, stat_mispred : capture counters, only when BRRES_STATS_EN is defined
// Optional feature macro: BRRES_STATS_EN
module branch_resolve_arb #(
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  branch_resolve_arb_if.slave bus
`ifdef BRRES_STATS_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred
`endif
);

  logic             rr_ptr;
  logic             free;
  logic             gnt;       // a transfer happens this cycle
  logic             gnt_lane;
  logic             sel;       // lane driving the comparator and capture muxes
  logic             pred_sel;
  logic [63:0]      pc_sel, tgt_sel;
  logic [TAG_W-1:0] tag_sel;

  always_comb begin
    free     = !bus.res_valid || bus.res_ready;
    // rst_n gates the grant so nothing handshakes while reset is held
    gnt      = rst_n && !bus.flush && free && (|bus.req_valid);
    gnt_lane = (&bus.req_valid) ? rr_ptr : bus.req_valid[1];
    // idle cycles park the mux on rr_ptr so cmp_* never floats
    sel      = gnt ? gnt_lane : rr_ptr;

    bus.req_ready = 2'b00;
    if (gnt) bus.req_ready = sel ? 2'b10 : 2'b01;

    bus.cmp_op = sel ? bus.req_op1   : bus.req_op0;
    bus.cmp_r1 = sel ? bus.req_r1_1  : bus.req_r1_0;
    bus.cmp_r2 = sel ? bus.req_r2_1  : bus.req_r2_0;
    pred_sel   = sel ? bus.req_pred1 : bus.req_pred0;
    pc_sel     = sel ? bus.req_pc1   : bus.req_pc0;
    tgt_sel    = sel ? bus.req_tgt1  : bus.req_tgt0;
    tag_sel    = sel ? bus.req_tag1  : bus.req_tag0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr              <= 1'b0;
      bus.res_valid       <= 1'b0;
      bus.res_lane        <= 1'b0;
      bus.res_tag         <= '0;
      bus.res_taken       <= 1'b0;
      bus.res_mispredict  <= 1'b0;
      bus.res_redirect_pc <= '0;
`ifdef BRRES_STATS_EN
      stat_resolved       <= '0;
      stat_mispred        <= '0;
`endif
    end else if (bus.flush) begin
      // payload and rr_ptr deliberately keep their value
      bus.res_valid <= 1'b0;
    end else if (gnt) begin
      rr_ptr              <= ~sel;
      bus.res_valid       <= 1'b1;
      bus.res_lane        <= sel;
      bus.res_tag         <= tag_sel;
      bus.res_taken       <= bus.cmp_taken;
      bus.res_mispredict  <= bus.cmp_taken ^ pred_sel;
      bus.res_redirect_pc <= bus.cmp_taken ? tgt_sel : pc_sel + 64'd4;
`ifdef BRRES_STATS_EN
      stat_resolved       <= stat_resolved + 32'd1;
      stat_mispred        <= stat_mispred + {31'd0, bus.cmp_taken ^ pred_sel};
`endif
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_arb.sv
module tb_branch_resolve_arb;
  localparam int TAG_W = 4;

  typedef struct {
    logic             lane;
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic             mis;
    logic [63:0]      redir;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_arb_if #(.TAG_W(TAG_W)) bus ();

`ifdef BRRES_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
  branch_resolve_arb #(.TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred));
`else
  branch_resolve_arb #(.TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // stimulus per lane
  logic [1:0]       t_vld;
  logic             t_flush, t_rdy;
  logic [2:0]       t_op   [2];
  logic [63:0]      t_r1   [2];
  logic [63:0]      t_r2   [2];
  logic [63:0]      t_pc   [2];
  logic [63:0]      t_tgt  [2];
  logic             t_pred [2];
  logic [TAG_W-1:0] t_tag  [2];

  function automatic logic cmpf(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0: return 1'b1;
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return $signed(a) <  $signed(b);
      3'd4: return $signed(a) >= $signed(b);
      3'd5: return a <  b;
      3'd6: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign bus.flush     = t_flush;
  assign bus.res_ready = t_rdy;
  assign bus.req_valid = t_vld;
  assign bus.req_op0 = t_op[0];   assign bus.req_op1 = t_op[1];
  assign bus.req_r1_0 = t_r1[0];  assign bus.req_r1_1 = t_r1[1];
  assign bus.req_r2_0 = t_r2[0];  assign bus.req_r2_1 = t_r2[1];
  assign bus.req_pc0 = t_pc[0];   assign bus.req_pc1 = t_pc[1];
  assign bus.req_tgt0 = t_tgt[0]; assign bus.req_tgt1 = t_tgt[1];
  assign bus.req_pred0 = t_pred[0]; assign bus.req_pred1 = t_pred[1];
  assign bus.req_tag0 = t_tag[0]; assign bus.req_tag1 = t_tag[1];
  // comparator model, combinational off the DUT's operand mux
  assign bus.cmp_taken = cmpf(bus.cmp_op, bus.cmp_r1, bus.cmp_r2);

  int n_tests = 0, n_fail = 0;
  exp_t q[$];
  logic exp_valid = 1'b0, exp_rr = 1'b0, rst_hold = 1'b0;
  logic [31:0] exp_res = 0, exp_mis = 0;
  logic [TAG_W-1:0] tag_ctr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic new_req(input int l);
    logic [63:0] a;
    a = {$urandom, $urandom};
    t_op[l]   = 3'($urandom_range(0, 6));
    t_r1[l]   = a;
    t_r2[l]   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
    t_pc[l]   = {$urandom, $urandom[31:2], 2'b00};
    t_tgt[l]  = {$urandom, $urandom[31:2], 2'b00};
    t_pred[l] = 1'($urandom);
    t_tag[l]  = tag_ctr;
    tag_ctr++;
  endtask

  // checks outputs mid-cycle, then advances the reference model across the coming edge
  task automatic step();
    logic can, gl;
    logic [1:0] er;
    exp_t e;
    can = rst_n && !t_flush && (!exp_valid || t_rdy);
    gl  = (&t_vld) ? exp_rr : t_vld[1];
    er  = (can && (|t_vld)) ? (gl ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("res_valid", 64'(bus.res_valid), 64'(exp_valid));
    if (rst_hold) begin
      chk("rst_lane",  64'(bus.res_lane), 0);
      chk("rst_tag",   64'(bus.res_tag), 0);
      chk("rst_taken", 64'(bus.res_taken), 0);
      chk("rst_mis",   64'(bus.res_mispredict), 0);
      chk("rst_redir", bus.res_redirect_pc, 0);
    end
    if (exp_valid) begin
      e = q[0];
      chk("res_lane",  64'(bus.res_lane), 64'(e.lane));
      chk("res_tag",   64'(bus.res_tag), 64'(e.tag));
      chk("res_taken", 64'(bus.res_taken), 64'(e.taken));
      chk("res_mis",   64'(bus.res_mispredict), 64'(e.mis));
      chk("res_redir", bus.res_redirect_pc, e.redir);
    end
`ifdef BRRES_STATS_EN
    if (rst_hold || exp_res != 0) begin
      chk("stat_resolved", 64'(stat_resolved), 64'(exp_res));
      chk("stat_mispred",  64'(stat_mispred), 64'(exp_mis));
    end
`endif
    rst_hold = !rst_n;
    if (!rst_n) begin
      q.delete(); exp_valid = 0; exp_rr = 0; exp_res = 0; exp_mis = 0;
    end else if (t_flush) begin
      if (exp_valid) void'(q.pop_front());
      exp_valid = 0;
    end else begin
      if (exp_valid && t_rdy) begin void'(q.pop_front()); exp_valid = 0; end
      if (er != 2'b00) begin
        e.lane  = gl;
        e.tag   = t_tag[gl];
        e.taken = cmpf(t_op[gl], t_r1[gl], t_r2[gl]);
        e.mis   = e.taken ^ t_pred[gl];
        e.redir = e.taken ? t_tgt[gl] : t_pc[gl] + 64'd4;
        q.push_back(e);
        exp_valid = 1; exp_rr = ~gl;
        exp_res++; if (e.mis) exp_mis++;
      end
    end
  endtask

  task automatic cyc();
    #2 step();
    @(posedge clk); #1;
  endtask

  task automatic both_new();
    new_req(0); new_req(1);
  endtask

  initial begin
    rst_n = 0; t_flush = 0; t_rdy = 1; t_vld = 2'b11;
    both_new();
    @(posedge clk); #1;
    repeat (2) cyc();
    rst_n = 1;

    // lane 0 EQ 5==5, predicted not-taken: taken, mispredict, redirect to tgt
    t_vld = 2'b01; new_req(0);
    t_op[0] = 3'd1; t_r1[0] = 64'd5; t_r2[0] = 64'd5; t_pred[0] = 0;
    t_pc[0] = 64'h100; t_tgt[0] = 64'h200;
    cyc();
    t_vld = 2'b00;
    cyc();
    chk("t1_redir", bus.res_redirect_pc, 64'h200);

    // both lanes every cycle: alternating grants, one result per cycle
    t_vld = 2'b11;
    repeat (8) begin both_new(); cyc(); end

    // stall with both valid, then drain and refill together
    t_rdy = 0;
    repeat (3) begin both_new(); cyc(); end
    t_rdy = 1; both_new(); cyc();
    t_vld = 2'b00; cyc();

    // lane 1 at the top of the address space: signed LT taken, then unsigned LT wraps pc+4
    t_vld = 2'b10; new_req(1);
    t_op[1] = 3'd3; t_r1[1] = '1; t_r2[1] = 64'd1; t_pred[1] = 1;
    t_pc[1] = 64'hFFFF_FFFF_FFFF_FFFC; t_tgt[1] = 64'h4000;
    cyc();
    t_op[1] = 3'd5; t_tag[1] = tag_ctr; tag_ctr++;
    cyc();
    t_vld = 2'b00;
    cyc();
    chk("wrap_redir", bus.res_redirect_pc, 64'h0);

    // flush while holding a result, both lanes pending
    t_vld = 2'b11; both_new(); cyc();
    t_rdy = 0; t_flush = 1; both_new(); cyc();
    t_flush = 0; t_rdy = 1; both_new(); cyc();
    both_new(); cyc();

    // reset in the middle of back-to-back transfers
    repeat (3) begin both_new(); cyc(); end
    rst_n = 0;
    repeat (2) begin both_new(); cyc(); end
    rst_n = 1;

    // five always-taken captures, two predicted not-taken
    t_vld = 2'b01;
    for (int i = 0; i < 5; i++) begin
      new_req(0); t_op[0] = 3'd0; t_pred[0] = (i % 2 == 0); cyc();
    end
    t_vld = 2'b00; cyc();
`ifdef BRRES_STATS_EN
    chk("stat5_res", 64'(stat_resolved), 64'd5);
    chk("stat5_mis", 64'(stat_mispred), 64'd2);
`endif

    // random traffic including flushes and backpressure
    for (int i = 0; i < 80; i++) begin
      t_vld   = 2'($urandom);
      t_rdy   = ($urandom_range(0, 3) != 0);
      t_flush = ($urandom_range(0, 7) == 0);
      both_new();
      cyc();
    end
    t_flush = 0; t_rdy = 1; t_vld = 2'b00;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
